// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Also detects load-use hazards and handles stall, flush and bubble insertion.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_func3,
  input  logic [3:0]      id_alu_sel,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] ex_in1,
  output logic [XLEN-1:0] ex_in2,
  output logic [2:0]      ex_func3,
  output logic [3:0]      ex_alu_sel,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            load_use_stall
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [2:0]      r_func3;
  logic [3:0]      r_alu_sel;
  logic            r_alu_src;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic            w_hazard;

  // Load in EX whose destination is read by the instruction waiting in ID.
  assign w_hazard = r_valid & r_mem_read & id_valid & (r_rd != 5'd0) &
                    ((r_rd == id_rs1) | (r_rd == id_rs2));
  // A flush kills the ID instruction anyway, so no bubble is needed.
  assign load_use_stall = w_hazard & ~flush;

  // Pipeline register update: flush > stall > bubble > load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_func3     <= '0;
      r_alu_sel   <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (load_use_stall) begin
      r_valid <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_pc        <= id_pc;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_func3     <= id_func3;
      r_alu_sel   <= id_alu_sel;
      r_alu_src   <= id_alu_src;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_branch    <= id_branch;
    end
  end

  // Operand forwarding; the younger EX/MEM result wins, x0 never forwards.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs1)) begin
      w_fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs1)) begin
      w_fwd_rs1 = memwb_result;
    end
    w_fwd_rs2 = r_rs2_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs2)) begin
      w_fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs2)) begin
      w_fwd_rs2 = memwb_result;
    end
  end

  assign ex_in1        = w_fwd_rs1;
  assign ex_in2        = r_alu_src ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;

  // Bubbles keep stale ALU codes; only side-effecting controls are gated.
  assign ex_func3     = r_func3;
  assign ex_alu_sel   = r_alu_sel;
  assign ex_pc        = r_pc;
  assign ex_rd        = r_rd;
  assign ex_valid     = r_valid;
  assign ex_reg_write = r_reg_write & r_valid;
  assign ex_mem_read  = r_mem_read & r_valid;
  assign ex_mem_write = r_mem_write & r_valid;
  assign ex_branch    = r_branch & r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, corner sequences, random vs model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_func3;
  logic [3:0]  id_alu_sel;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;
  logic [2:0]  ex_func3;
  logic [3:0]  ex_alu_sel;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_func3(id_func3),
    .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .stall(stall), .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_func3(ex_func3),
    .ex_alu_sel(ex_alu_sel), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .load_use_stall(load_use_stall)
  );

  // Reference model: the instruction currently occupying EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  sel;
    logic        src, rw, mr, mw, br;
  } instr_t;

  instr_t m = '0;

  typedef struct packed {
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2;
    logic        src;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic [31:0] e_in1, e_in2, e_sd;
  } vec_t;

  vec_t vecs [7];

  function automatic instr_t id_now();
    instr_t r;
    r.valid = id_valid; r.pc = id_pc; r.rs1d = id_rs1_data; r.rs2d = id_rs2_data;
    r.imm = id_imm; r.rs1 = id_rs1; r.rs2 = id_rs2; r.rd = id_rd; r.f3 = id_func3;
    r.sel = id_alu_sel; r.src = id_alu_src; r.rw = id_reg_write; r.mr = id_mem_read;
    r.mw = id_mem_write; r.br = id_branch;
    return r;
  endfunction

  // Value a source register holds once the newest in-flight writes are applied.
  function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  function automatic logic model_lu();
    if (flush || !(m.valid && m.mr && id_valid) || m.rd == 5'd0) return 1'b0;
    return (m.rd == id_rs1) || (m.rd == id_rs2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] f2;
    f2 = src_val(m.rs2, m.rs2d);
    chk("in1", ex_in1, src_val(m.rs1, m.rs1d));
    chk("in2", ex_in2, m.src ? m.imm : f2);
    chk("store_data", ex_store_data, f2);
    chk("pc", ex_pc, m.pc);
    chk("rd", 32'(ex_rd), 32'(m.rd));
    chk("func3", 32'(ex_func3), 32'(m.f3));
    chk("alu_sel", 32'(ex_alu_sel), 32'(m.sel));
    chk("valid", 32'(ex_valid), 32'(m.valid));
    chk("reg_write", 32'(ex_reg_write), 32'(m.rw && m.valid));
    chk("mem_read", 32'(ex_mem_read), 32'(m.mr && m.valid));
    chk("mem_write", 32'(ex_mem_write), 32'(m.mw && m.valid));
    chk("branch", 32'(ex_branch), 32'(m.br && m.valid));
    chk("load_use", 32'(load_use_stall), 32'(model_lu()));
  endtask

  // One clock: model advances from the inputs present before the edge.
  task automatic tick();
    instr_t nxt;
    nxt = m;
    if (flush) nxt.valid = 1'b0;
    else if (stall) nxt = m;
    else if (model_lu()) nxt.valid = 1'b0;
    else nxt = id_now();
    @(posedge clk);
    if (rst) m = nxt;
    else m = '0;
    #1;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] r1d, input logic [31:0] r2d,
                        input logic [31:0] imm, input logic src, input logic rw,
                        input logic mr, input logic mw);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm; id_alu_src = src;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = 0;
    id_func3 = 3'd0; id_alu_sel = 4'd0;
  endtask

  task automatic rand_inputs();
    id_valid = ($urandom_range(0, 4) != 0);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3)); id_func3 = 3'($urandom); id_alu_sel = 4'($urandom);
    id_alu_src = 1'($urandom); id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
    id_mem_write = 1'($urandom); id_branch = 1'($urandom);
    stall = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 7) == 0);
    exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
    exmem_result = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
    memwb_result = $urandom;
  endtask

  initial begin
    vecs[0] = '{32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'd5, 32'd7, 32'd9};
    vecs[1] = '{32'h11, 32'h22, 32'h0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3,
                32'hBB, 32'hAA, 32'h22, 32'h22};
    vecs[2] = '{32'h11, 32'h22, 32'h0, 5'd3, 5'd5, 1'b0, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3,
                32'hBB, 32'hBB, 32'h22, 32'h22};
    vecs[3] = '{32'h11, 32'h22, 32'h0, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0,
                32'hBB, 32'h11, 32'h22, 32'h22};
    vecs[4] = '{32'h1, 32'h99, 32'h40, 5'd1, 5'd6, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6,
                32'h1234, 32'h1, 32'h40, 32'h1234};
    vecs[5] = '{32'h55, 32'h66, 32'h0, 5'd8, 5'd7, 1'b0, 1'b1, 5'd7, 32'hDEAD, 1'b1, 5'd7,
                32'hBEEF, 32'h55, 32'hDEAD, 32'hDEAD};
    vecs[6] = '{32'h55, 32'h66, 32'h0, 5'd8, 5'd7, 1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd8,
                32'h77, 32'h77, 32'h66, 32'h66};

    // Reset state, with a forward source targeting x0 that must be ignored.
    set_id(32'h500, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 0; flush = 0;
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hEEEE_EEEE;
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_alu_sel", 32'(ex_alu_sel), 32'd0);
    chk("rst_in1", ex_in1, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_lu", 32'(load_use_stall), 32'd0);
    @(negedge clk); rst = 1;
    no_fwd();

    // Table-driven forwarding vectors.
    for (int i = 0; i < 7; i++) begin
      set_id(32'h100 + 32'(i * 4), vecs[i].rs1, vecs[i].rs2, 5'd10, vecs[i].rs1d,
             vecs[i].rs2d, vecs[i].imm, vecs[i].src, 1'b1, 1'b0, 1'b0);
      no_fwd();
      tick();
      exmem_reg_write = vecs[i].exw; exmem_rd = vecs[i].exrd; exmem_result = vecs[i].exres;
      memwb_reg_write = vecs[i].wbw; memwb_rd = vecs[i].wbrd; memwb_result = vecs[i].wbres;
      #1;
      chk($sformatf("vec%0d_in1", i), ex_in1, vecs[i].e_in1);
      chk($sformatf("vec%0d_in2", i), ex_in2, vecs[i].e_in2);
      chk($sformatf("vec%0d_store", i), ex_store_data, vecs[i].e_sd);
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'd1);
    end

    // Load-use: lw x4 in EX, dependent add in ID -> one bubble, then MEM/WB forward.
    no_fwd();
    set_id(32'h300, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(32'h304, 5'd1, 5'd4, 5'd5, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("lu_assert", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_mw", 32'(ex_mem_write), 32'd0);
    chk("lu_bubble_mr", 32'(ex_mem_read), 32'd0);
    chk("lu_drop", 32'(load_use_stall), 32'd0);
    tick();
    memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 32'h4444;
    #1;
    chk("lu_load_valid", 32'(ex_valid), 32'd1);
    chk("lu_load_pc", ex_pc, 32'h304);
    chk("lu_load_in2", ex_in2, 32'h4444);
    chk("lu_load_mw", 32'(ex_mem_write), 32'd1);

    // Stall with a pending hazard: stage holds, hazard persists.
    no_fwd();
    set_id(32'h400, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(32'h404, 5'd4, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 1;
    tick();
    chk("stall_lu_valid", 32'(ex_valid), 32'd1);
    chk("stall_lu_pc", ex_pc, 32'h400);
    chk("stall_lu_persist", 32'(load_use_stall), 32'd1);

    // Flush beats stall; flush also masks the hazard.
    flush = 1;
    #1;
    chk("flush_masks_lu", 32'(load_use_stall), 32'd0);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(ex_reg_write), 32'd0);
    flush = 0; stall = 0;

    // Three-cycle stall holds everything.
    set_id(32'h200, 5'd2, 5'd3, 5'd9, 32'h31, 32'h32, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      set_id(32'h900 + 32'(c), 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      chk($sformatf("hold%0d_pc", c), ex_pc, 32'h200);
      chk($sformatf("hold%0d_rd", c), 32'(ex_rd), 32'd9);
      chk($sformatf("hold%0d_in1", c), ex_in1, 32'h31);
      chk($sformatf("hold%0d_valid", c), 32'(ex_valid), 32'd1);
    end
    stall = 0;

    // Asynchronous reset mid-cycle discards an in-flight instruction.
    set_id(32'h600, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    id_alu_sel = 4'b1010;
    tick();
    chk("pre_rst_sel", 32'(ex_alu_sel), 32'hA);
    #2; rst = 0; #1;
    m = '0;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_alu_sel", 32'(ex_alu_sel), 32'd0);
    chk("arst_rw", 32'(ex_reg_write), 32'd0);
    #2; rst = 1;
    set_id(32'h700, 5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_pc", ex_pc, 32'h700);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      #1;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined RV32 core. It registers decoded operands and control from the decode stage and resolves EX/MEM and MEM/WB forwarding onto `ex_in1`/`ex_in2`, `ex_func3` and `ex_alu_sel`, which feed the ALU directly. It also detects load-use hazards and supports stall, flush and bubble insertion.

## Interface
- `XLEN`, 32, datapath width
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous reset, active-low
- `id_valid` in 1: decode slot holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN: decoded PC, register-file reads, immediate
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices
- `id_func3` in 3, `id_alu_sel` in 4: ALU controls, using the ALU's encodings
- `id_alu_src` in 1: 1 selects immediate for operand 2
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch` in 1: control bits
- `stall` in 1: hold stage (downstream back-pressure)
- `flush` in 1: squash stage (taken branch or jump)
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in XLEN: EX/MEM forward source
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in XLEN: MEM/WB forward source
- `ex_in1`, `ex_in2` out XLEN: ALU operands
- `ex_func3` out 3, `ex_alu_sel` out 4: to ALU
- `ex_store_data` out XLEN: forwarded rs2, for stores
- `ex_pc` out XLEN, `ex_rd` out 5, `ex_valid` out 1
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` out 1: gated by `ex_valid`
- `load_use_stall` out 1: to PC and IF/ID, which must hold

## Operation
- **Registers.** Hold pc, rs1/rs2 data, imm, rs1/rs2/rd indices, func3, alu_sel, alu_src, four control bits and valid.
- **Update priority each edge:** `flush` > `stall` > `load_use_stall` > load.
  - `flush`: valid←0. Other fields are don't-care.
  - `stall`: every register holds.
  - `load_use_stall`: valid←0, inserting a bubble.
  - Otherwise all registers load from the `id_*` inputs.
- **`load_use_stall` (combinational):** asserted when `ex_valid & ex_mem_read & id_valid & (ex_rd != 0)` and `ex_rd` matches `id_rs1`, or `ex_rd` matches `id_rs2`. It is masked to 0 while `flush` is high.
- **Forwarding (combinational) for each source s ∈ {rs1, rs2}:**
  - If `exmem_reg_write & exmem_rd != 0 & exmem_rd == s`: use `exmem_result`.
  - Else if the same test passes against `memwb_*`: use `memwb_result`.
  - Else use the registered data.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
- **ALU operands:**
  - `ex_in1` = forwarded rs1.
  - `ex_in2` = alu_src ? imm : forwarded rs2.
  - `ex_store_data` = forwarded rs2, always.
- **Gating:** `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` = registered bit & `ex_valid`.
- **Pass-through:** `ex_func3` and `ex_alu_sel` pass straight from their registers. A bubble therefore carries stale codes, but all its side effects are gated off.

## Timing
- **Latency:** one cycle from `id_*` to `ex_*` registers. The forwarding muxes add no cycle; operands are valid in the same cycle as the forward sources.
- **Reset (async, `rst`=0):** all registers clear immediately.
  - `ex_valid`=0, `ex_pc`=0, `ex_rd`=0, `ex_func3`=0, `ex_alu_sel`=4'b0000 (add), and all control outputs 0.
  - `ex_in1`/`ex_in2`/`ex_store_data` become 0 unless a forward source matches a cleared index. Indices clear to 0 and x0 is never forwarded, so they are 0.
  - `load_use_stall`=0.
- **Reset release:** synchronous to `clk`. The first edge after release loads normally.
- **Load-use:** exactly one bubble per hazard. On the next cycle `ex_mem_read` reflects the bubble, so `load_use_stall` drops. The held decode instruction then loads, and the data arrives via MEM/WB forwarding.
- **`stall` with `load_use_stall`:** `stall` wins and the stage holds. The hazard condition persists and is re-evaluated each cycle.
- **`flush` with `stall`:** `flush` wins and the stage goes invalid.
- **Reset mid-operation:** an in-flight instruction is discarded, with no partial side effects.

## Test plan
- **Basic load:** load `id_rs1_data`=5, `id_imm`=7, `alu_src`=1, `alu_sel`=0000, no forwards. Next cycle: `ex_in1`=5, `ex_in2`=7, `ex_valid`=1.
- **Forward priority:** rs1=x3 with `exmem_rd`=3 (result 0xAA) and `memwb_rd`=3 (result 0xBB), both `reg_write`=1 → `ex_in1`=0xAA. Drop `exmem_reg_write` → 0xBB. Set rd=0 on both → registered data.
- **Load-use:** EX holds lw x4 (`mem_read`=1, valid); ID has `id_rs2`=4 → `load_use_stall`=1. Next cycle `ex_valid`=0 and `ex_mem_write`=0, then the held instruction loads with `load_use_stall`=0.
- **Flush beats stall:** assert `flush`=1 and `stall`=1 together → next cycle `ex_valid`=0 and `ex_reg_write`=0. `stall` alone for 3 cycles → all outputs constant.
- **Async reset:** drop `rst` mid-cycle while `ex_valid`=1 and `ex_reg_write`=1. Without waiting for a clock edge: `ex_valid`=0, `ex_alu_sel`=0, `ex_reg_write`=0.
- **Store data:** `alu_src`=1 with rs2 forwarded from MEM/WB (0x1234) → `ex_in2`=imm and `ex_store_data`=0x1234.
